onehot_hold_decoder: RTL and testbench

//   Parametrised, registered successor to the 2-to-4 one-hot decoder. Decodes a SEL_W-bit code into
//   NUM_OUT one-hot lines. Each decoded line is held for HOLD cycles. Codes are accepted through a

---
 rtl/onehot_hold_decoder.sv | 134 +++++++++++++
 tb/tb_onehot_hold_decoder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/onehot_hold_decoder.sv
// ============================================================================
// Module      : onehot_hold_decoder
// Description : Registered, parametrised one-hot decoder with valid/ready
//               handshake, per-code hold time, out-of-range error pulse and
//               synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_hold_decoder #(
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned NUM_OUT   = 4,
  parameter int unsigned HOLD      = 1,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               clr,
  output logic [NUM_OUT-1:0] out,
  output logic               out_valid,
  output logic               err
);

  // Counter only needs to reach HOLD-1, but HOLD+1 keeps CNT_W >= 1 for HOLD=1.
  localparam int unsigned CNT_W = $clog2(HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  // One extra bit so NUM_OUT == 2**SEL_W is representable in the range check.
  localparam logic [SEL_W:0] NUM_OUT_EXT = (SEL_W + 1)'(NUM_OUT);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_OUT-1:0] out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               err_q, err_d;

  logic [NUM_OUT-1:0] dec;
  logic               code_ok;
  logic               accept;

  // Per-line decode: line j fires for the code mapped onto it by MSB_FIRST.
  for (genvar j = 0; j < NUM_OUT; j++) begin : g_decode
    localparam int unsigned CODE = MSB_FIRST ? (NUM_OUT - 1 - j) : j;
    assign dec[j] = (in_sel == SEL_W'(CODE));
  end

  assign code_ok = ({1'b0, in_sel} < NUM_OUT_EXT);

  // Ready while idle, or in the final hold cycle so back-to-back codes have no bubble.
  assign in_ready = rst_n && ((state_q == ST_IDLE) || (cnt_q == CNT_ZERO));
  assign accept   = in_valid && in_ready && !clr;

  // Next-state and registered-output computation; clr outranks any accept.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    err_d       = 1'b0;

    if (clr) begin
      state_d     = ST_IDLE;
      cnt_d       = CNT_ZERO;
      out_d       = '0;
      out_valid_d = 1'b0;
    end else if (accept) begin
      if (code_ok) begin
        state_d     = ST_HOLD;
        cnt_d       = CNT_LOAD;
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        // Out-of-range code: drop any current output and pulse err once.
        state_d     = ST_IDLE;
        cnt_d       = CNT_ZERO;
        out_d       = '0;
        out_valid_d = 1'b0;
        err_d       = 1'b1;
      end
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            state_d     = ST_IDLE;
            out_d       = '0;
            out_valid_d = 1'b0;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          cnt_d       = CNT_ZERO;
          out_d       = '0;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_ZERO;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_onehot_hold_decoder.sv
// ============================================================================
// Module      : tb_onehot_hold_decoder
// Description : Self-checking bench; four parametrisations share stimulus and
//               are compared each cycle against an interval-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_onehot_hold_decoder;

  localparam int NI = 4;
  // Instance parameters: A default-like, B short range/long hold, C LSB-first 8-wide, D odd range.
  localparam int P_SELW [NI] = '{2, 2, 3, 3};
  localparam int P_NUM  [NI] = '{4, 3, 8, 5};
  localparam int P_HOLD [NI] = '{1, 3, 4, 2};
  localparam int P_MSB  [NI] = '{1, 1, 0, 0};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] in_sel;
  logic       clr;

  logic [3:0] out_a;
  logic [2:0] out_b;
  logic [7:0] out_c;
  logic [4:0] out_d;
  logic       rdy [NI];
  logic       vld [NI];
  logic       erp [NI];
  logic [7:0] obs_out [NI];

  assign obs_out[0] = {4'b0, out_a};
  assign obs_out[1] = {5'b0, out_b};
  assign obs_out[2] = out_c;
  assign obs_out[3] = {3'b0, out_d};

  always #5 clk = ~clk;

  onehot_hold_decoder #(.SEL_W(2), .NUM_OUT(4), .HOLD(1), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]), .in_sel(in_sel[1:0]),
    .clr(clr), .out(out_a), .out_valid(vld[0]), .err(erp[0]));
  onehot_hold_decoder #(.SEL_W(2), .NUM_OUT(3), .HOLD(3), .MSB_FIRST(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]), .in_sel(in_sel[1:0]),
    .clr(clr), .out(out_b), .out_valid(vld[1]), .err(erp[1]));
  onehot_hold_decoder #(.SEL_W(3), .NUM_OUT(8), .HOLD(4), .MSB_FIRST(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]), .in_sel(in_sel),
    .clr(clr), .out(out_c), .out_valid(vld[2]), .err(erp[2]));
  onehot_hold_decoder #(.SEL_W(3), .NUM_OUT(5), .HOLD(2), .MSB_FIRST(1'b0)) u_d (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[3]), .in_sel(in_sel),
    .clr(clr), .out(out_d), .out_valid(vld[3]), .err(erp[3]));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model: a decoded code is shown over the cycle interval [accept+1, m_last].
  bit m_vld  [NI];
  bit m_err  [NI];
  int m_code [NI];
  int m_last [NI];

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int unsigned exp_out(input int i);
    if (!m_vld[i]) return 0;
    if (P_MSB[i] != 0) return 1 << (P_NUM[i] - 1 - m_code[i]);
    return 1 << m_code[i];
  endfunction

  function automatic bit exp_rdy(input int i);
    return rst_n && (!m_vld[i] || cyc == m_last[i]);
  endfunction

  function automatic int sel_for(input int i, input logic [2:0] s);
    return (P_SELW[i] == 2) ? int'(s[1:0]) : int'(s);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_vld[i] = 0; m_err[i] = 0; m_code[i] = 0; m_last[i] = 0;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("i%0d_out", i), obs_out[i], exp_out(i));
      check($sformatf("i%0d_out_valid", i), vld[i], m_vld[i]);
      check($sformatf("i%0d_err", i), erp[i], m_err[i]);
      check($sformatf("i%0d_in_ready", i), rdy[i], exp_rdy(i));
    end
  endtask

  // Called at a negedge: drive, check, advance one clock, land on the next negedge.
  task automatic step(input bit v, input logic [2:0] s, input bit c);
    bit pre_rdy [NI];
    in_valid = v; in_sel = s; clr = c;
    #1;
    check_all();
    for (int i = 0; i < NI; i++) pre_rdy[i] = exp_rdy(i);
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      int k;
      k = sel_for(i, s);
      m_err[i] = 0;
      if (c) begin
        m_vld[i] = 0;
      end else if (v && pre_rdy[i]) begin
        if (k < P_NUM[i]) begin
          m_vld[i] = 1; m_code[i] = k; m_last[i] = cyc + P_HOLD[i];
        end else begin
          m_vld[i] = 0; m_err[i] = 1;
        end
      end else if (m_vld[i] && cyc == m_last[i]) begin
        m_vld[i] = 0;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_sel = 3'd0; clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Sweep every code on consecutive cycles.
    for (int k = 0; k < 8; k++) step(1, 3'(k), 0);
    step(0, 0, 0);
    // Accept code 2 then hold code 1 continuously to exercise back-to-back ready.
    step(1, 3'd2, 0);
    repeat (6) step(1, 3'd1, 0);
    step(0, 0, 0);
    // Out-of-range codes followed by a valid one.
    step(1, 3'd3, 0); step(1, 3'd1, 0); step(1, 3'd6, 0);
    repeat (4) step(0, 0, 0);
    // Flush one cycle into a hold while offering a new code.
    step(1, 3'd0, 0); step(1, 3'd3, 1); step(0, 0, 0); step(1, 3'd5, 0);
    repeat (4) step(0, 0, 0);
    // Reset in the middle of a hold, then a normal accept.
    step(1, 3'd2, 0); step(0, 0, 0);
    async_reset();
    step(1, 3'd1, 0);
    repeat (4) step(0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 249) == 0) async_reset();
      step($urandom_range(0, 9) < 7, 3'($urandom), $urandom_range(0, 15) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
